// File: rtl/bcd_scan_display.sv
// Five-digit multiplexed BCD 7-segment scanner with leading-zero blanking,
// whole-display blink and a tear-free shadow copy of the digit inputs.
module bcd_scan_display #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic [3:0] digit6,
   input  logic [3:0] digit5,
   input  logic [3:0] digit4,
   input  logic [3:0] digit3,
   input  logic [3:0] digit2,
   input  logic       blank_lz,
   input  logic       blink_en,
   output logic [6:0] seg,
   output logic [4:0] an,
   output logic       frame_done
);

   localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]        PTR_LAST  = 3'd4;

   logic [PCNT_W-1:0] pcnt;
   logic [2:0]        ptr;
   logic [BCNT_W-1:0] blink_cnt;
   logic              blink_phase;
   logic [4:0][3:0]   shadow;
   logic              load_pending;

   logic              tick;
   logic              wrap_tick;
   logic [4:0][3:0]   digits_in;
   logic [4:0][3:0]   src;
   logic [4:0]        lz_blank;
   logic [3:0]        cur_digit;
   logic              show;
   logic [6:0]        seg_next;
   logic [4:0]        an_next;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h7E;
         4'd1:    s = 7'h30;
         4'd2:    s = 7'h6D;
         4'd3:    s = 7'h79;
         4'd4:    s = 7'h33;
         4'd5:    s = 7'h5B;
         4'd6:    s = 7'h5F;
         4'd7:    s = 7'h70;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h7B;
         default: s = 7'h01;
      endcase
      return s;
   endfunction

   // Index 0 is the rightmost digit so that slot number, ptr and an bit agree.
   assign digits_in = {digit6, digit5, digit4, digit3, digit2};

   assign tick      = (pcnt == PCNT_LAST);
   assign wrap_tick = tick && (ptr == PTR_LAST);

   // In the first cycle out of reset the shadow is still being loaded, so
   // decode straight from the inputs that are about to be captured.
   assign src       = load_pending ? digits_in : shadow;
   assign cur_digit = src[ptr];

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      logic zeros_left;
      lz_blank   = '0;
      zeros_left = 1'b1;
      for (int i = 4; i >= 1; i--) begin
         zeros_left  = zeros_left && (src[i] == 4'd0);
         lz_blank[i] = blank_lz && zeros_left;
      end
   end

   always_comb begin
      show     = EN && !(blink_en && blink_phase) && !lz_blank[ptr];
      seg_next = 7'h00;
      an_next  = 5'b00000;
      if (show) begin
         seg_next = bcd_to_seg(cur_digit);
         an_next  = 5'b00001 << ptr;
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pcnt         <= '0;
         ptr          <= '0;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
         // NOTE: the shadow is only five nibbles of flops, so it is cleared
         // like any other register rather than left unreset as a memory.
         shadow       <= '0;
         load_pending <= 1'b1;
         seg          <= '0;
         an           <= '0;
         frame_done   <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + PCNT_W'(1);

         if (tick) begin
            ptr <= (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
         end

         if (wrap_tick) begin
            if (blink_cnt == BCNT_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BCNT_W'(1);
            end
         end

         if (load_pending || wrap_tick) begin
            shadow <= digits_in;
         end
         load_pending <= 1'b0;

         frame_done <= wrap_tick;
         seg        <= seg_next;
         an         <= an_next;
      end
   end

endmodule
